// File: rtl/rs_seg_adder_pipe.sv
// rtl/rs_seg_adder_pipe.sv - pipelined segmented adder/subtractor, one SEG-bit slice per stage
// Optional signed-overflow output enabled by defining RS_SEG_ADDER_OVF_EN.
module rs_seg_adder_pipe #(
    parameter int WIDTH = 64,
    parameter int SEG   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             ci,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             co
`ifdef RS_SEG_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NSEG = (WIDTH + SEG - 1) / SEG;
    localparam int LAST = WIDTH - (NSEG - 1) * SEG;

    function automatic int slice_w(input int k);
        return (k == NSEG - 1) ? LAST : SEG;
    endfunction

    // operand bits still unconsumed after stage k (the skew triangle)
    function automatic int op_w(input int k);
        return (k >= NSEG - 1) ? 0 : WIDTH - (k + 1) * SEG;
    endfunction

    function automatic int op_off(input int k);
        int o = 0;
        for (int j = 0; j < k; j++) o += op_w(j);
        return o;
    endfunction

    function automatic int done_w(input int k);
        return (k == NSEG - 1) ? WIDTH : (k + 1) * SEG;
    endfunction

    function automatic int s_off(input int k);
        int o = 0;
        for (int j = 0; j < k; j++) o += done_w(j);
        return o;
    endfunction

    localparam int OP_BITS = op_off(NSEG);
    localparam int OPT     = (OP_BITS > 0) ? OP_BITS : 1;
    localparam int ST      = s_off(NSEG);

    logic [NSEG-1:0]  v_q, v_d, c_q, c_d;
    logic [OPT-1:0]   oa_q, oa_d, ob_q, ob_d;
    logic [ST-1:0]    s_q, s_d;
    logic [WIDTH-1:0] b_x;
    logic             adv;

    assign out_valid = v_q[NSEG-1];
    assign adv       = ~out_valid | out_ready;
    assign in_ready  = adv;
    assign b_x       = sub ? ~b : b;
    assign v_d       = (v_q << 1) | NSEG'(in_valid);
    assign y         = s_q[s_off(NSEG-1) +: WIDTH];
    assign co        = c_q[NSEG-1];

    if (OP_BITS == 0) begin : g_no_ops
        assign oa_d = '0;
        assign ob_d = '0;
    end

    for (genvar k = 0; k < NSEG; k++) begin : g_stage
        localparam int W = slice_w(k);
        logic [W-1:0] sa, sb;
        logic         cin;
        logic [W:0]   sum;

        if (k == 0) begin : g_first
            assign sa  = a[W-1:0];
            assign sb  = b_x[W-1:0];
            assign cin = ci;
            if (op_w(0) > 0) begin : g_pass
                assign oa_d[0 +: op_w(0)] = a[WIDTH-1:W];
                assign ob_d[0 +: op_w(0)] = b_x[WIDTH-1:W];
            end
            assign s_d[0 +: W] = sum[W-1:0];
        end else begin : g_next
            localparam int PO = op_off(k - 1);
            assign sa  = oa_q[PO +: W];
            assign sb  = ob_q[PO +: W];
            assign cin = c_q[k-1];
            if (op_w(k) > 0) begin : g_pass
                assign oa_d[op_off(k) +: op_w(k)] = oa_q[PO + W +: op_w(k)];
                assign ob_d[op_off(k) +: op_w(k)] = ob_q[PO + W +: op_w(k)];
            end
            // earlier sum slices ride along so the whole result leaves together
            assign s_d[s_off(k) +: done_w(k)] = {sum[W-1:0], s_q[s_off(k-1) +: done_w(k-1)]};
        end

        assign sum    = {1'b0, sa} + {1'b0, sb} + {{W{1'b0}}, cin};
        assign c_d[k] = sum[W];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q  <= '0;
            c_q  <= '0;
            s_q  <= '0;
            oa_q <= '0;
            ob_q <= '0;
        end else if (adv) begin
            v_q  <= v_d;
            c_q  <= c_d;
            s_q  <= s_d;
            oa_q <= oa_d;
            ob_q <= ob_d;
        end
    end

`ifdef RS_SEG_ADDER_OVF_EN
    logic [NSEG-1:0] am_q, am_d, bm_q, bm_d;

    assign am_d = (am_q << 1) | NSEG'(a[WIDTH-1]);
    assign bm_d = (bm_q << 1) | NSEG'(b_x[WIDTH-1]);
    assign ovf  = (am_q[NSEG-1] == bm_q[NSEG-1]) & (y[WIDTH-1] != am_q[NSEG-1]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            am_q <= '0;
            bm_q <= '0;
        end else if (adv) begin
            am_q <= am_d;
            bm_q <= bm_d;
        end
    end
`endif

endmodule

// File: tb/tb_rs_seg_adder_pipe.sv
// tb/tb_rs_seg_adder_pipe.sv - self-checking bench for rs_seg_adder_pipe (WIDTH=40, SEG=16)
module tb_rs_seg_adder_pipe;

    localparam int W = 40;
    localparam longint SMAX = (longint'(1) <<< (W - 1)) - 1;
    localparam longint SMIN = -(longint'(1) <<< (W - 1));

    typedef struct {
        logic [W-1:0] y;
        logic         co;
        logic         ovf;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, sub, ci, out_valid, out_ready, co;
    logic [W-1:0] a, b, y;
    logic         ovf_obs;

    int   n_assert = 0;
    int   n_fail   = 0;
    int   n_in     = 0;
    int   n_out    = 0;
    exp_t q[$];
    logic         prev_hold = 1'b0;
    logic [W-1:0] hold_y;
    logic         hold_co;

    rs_seg_adder_pipe #(.WIDTH(W), .SEG(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .ci(ci),
        .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .co(co)
`ifdef RS_SEG_ADDER_OVF_EN
        , .ovf(ovf_obs)
`endif
    );
`ifndef RS_SEG_ADDER_OVF_EN
    assign ovf_obs = 1'b0;
`endif

    always #5 clk = ~clk;

    // full-precision arithmetic; overflow from the signed range of the true sum
    function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                   input logic msub, input logic mci);
        exp_t       r;
        logic [W:0] full;
        longint     ssum;
        logic [W-1:0] bb;
        bb     = msub ? ~mb : mb;
        full   = {1'b0, ma} + {1'b0, bb} + (W + 1)'(mci);
        ssum   = longint'($signed(ma)) + longint'($signed(bb)) + longint'(mci);
        r.y    = full[W-1:0];
        r.co   = full[W];
        r.ovf  = (ssum > SMAX) || (ssum < SMIN);
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [W-1:0] da, input logic [W-1:0] db,
                         input logic ds, input logic dc);
        in_valid = v; a = da; b = db; sub = ds; ci = dc;
    endtask

    // sample scoreboard just before the edge, then advance one cycle
    task automatic tick();
        exp_t e;
        #1;
        if (prev_hold) begin
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_y", 64'(y), 64'(hold_y));
            check("hold_co", 64'(co), 64'(hold_co));
        end
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                check("spurious_out", 64'(out_valid), 64'd0);
            end else begin
                e = q.pop_front();
                n_out++;
                check("y", 64'(y), 64'(e.y));
                check("co", 64'(co), 64'(e.co));
`ifdef RS_SEG_ADDER_OVF_EN
                check("ovf", 64'(ovf_obs), 64'(e.ovf));
`endif
            end
        end
        prev_hold = out_valid && !out_ready;
        hold_y    = y;
        hold_co   = co;
        if (in_valid && in_ready) begin
            q.push_back(model(a, b, sub, ci));
            n_in++;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        out_ready = 1'b1;
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_y", 64'(y), 64'd0);
        check("rst_co", 64'(co), 64'd0);
        check("rst_ovf", 64'(ovf_obs), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 64'(in_ready), 64'd1);

        // full-chain carry ripple, latency 3
        drive(1'b1, 40'hFF_FFFF_FFFF, '0, 1'b0, 1'b1);
        tick();
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        check("lat1_c1", 64'(out_valid), 64'd0);
        tick();
        check("lat1_c2", 64'(out_valid), 64'd0);
        tick();
        check("lat1_c3", 64'(out_valid), 64'd1);
        check("wrap_y", 64'(y), 64'd0);
        check("wrap_co", 64'(co), 64'd1);
        tick();

        // subtract across a slice boundary, then negative result
        drive(1'b1, 40'h00_0001_0000, 40'h1, 1'b1, 1'b1);
        tick();
        drive(1'b1, 40'h0, 40'h1, 1'b1, 1'b1);
        tick();
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        tick();
        check("sub1_y", 64'(y), 64'h00_0000_FFFF);
        check("sub1_co", 64'(co), 64'd1);
        tick();
        check("sub2_y", 64'(y), 64'hFF_FFFF_FFFF);
        check("sub2_co", 64'(co), 64'd0);
        tick();

        // signed overflow corner
        drive(1'b1, 40'h7F_FFFF_FFFF, 40'h1, 1'b0, 1'b0);
        tick();
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        tick();
        tick();
        check("ovf_y", 64'(y), 64'h80_0000_0000);
`ifdef RS_SEG_ADDER_OVF_EN
        check("ovf_flag", 64'(ovf_obs), 64'd1);
`endif
        tick();

        // full pipe held for 5 cycles, then drains on 3 consecutive cycles
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, W'({$urandom(), $urandom()}), W'({$urandom(), $urandom()}),
                  1'($urandom()), 1'($urandom()));
            tick();
        end
        drive(1'b1, 40'h12_3456_789A, 40'h1, 1'b0, 1'b0);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_in_ready", 64'(in_ready), 64'd0);
            check("bp_out_valid", 64'(out_valid), 64'd1);
            tick();
        end
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("drain_valid", 64'(out_valid), 64'd1);
            tick();
        end
        check("drain_done", 64'(out_valid), 64'd0);
        check("drain_q", 64'(q.size()), 64'd0);

        // async reset with 2 beats in flight, first already at the output
        drive(1'b1, 40'h1, 40'h2, 1'b0, 1'b0);
        tick();
        drive(1'b1, 40'h3, 40'h4, 1'b0, 1'b0);
        tick();
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        tick();
        out_ready = 1'b0;
        #1;
        check("pre_rst_valid", 64'(out_valid), 64'd1);
        rst = 1'b1;
        #1;
        check("rst_async_valid", 64'(out_valid), 64'd0);
        check("rst_async_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        q.delete();
        prev_hold = 1'b0;
        drive(1'b1, 40'hAB_CDEF_0123, 40'h11_1111_1111, 1'b0, 1'b1);
        tick();
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        check("lat2_c1", 64'(out_valid), 64'd0);
        tick();
        check("lat2_c2", 64'(out_valid), 64'd0);
        tick();
        check("lat2_c3", 64'(out_valid), 64'd1);
        check("lat2_y", 64'(y), 64'hBC_DF00_1235);
        tick();
        check("lat2_after", 64'(out_valid), 64'd0);

        // random stream with random backpressure
        n_in = 0;
        n_out = 0;
        for (int i = 0; i < 1000; i++) begin
            logic [W-1:0] ra, rb;
            ra = ($urandom_range(0, 9) == 0) ? '1 : W'({$urandom(), $urandom()});
            rb = ($urandom_range(0, 9) == 0) ? '0 : W'({$urandom(), $urandom()});
            drive(1'($urandom_range(0, 3) != 0), ra, rb, 1'($urandom()), 1'($urandom()));
            out_ready = 1'($urandom_range(0, 3) != 0);
            tick();
        end
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        out_ready = 1'b1;
        for (int i = 0; i < 10 && q.size() != 0; i++) tick();
        check("stream_q_empty", 64'(q.size()), 64'd0);
        check("stream_count", 64'(n_out), 64'(n_in));
        tick();
        check("stream_idle", 64'(out_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/rs_seg_adder_pipe.md
# rs_seg_adder_pipe

Pipelined segmented adder/subtractor for operands wider than one Genesis3 carry chain. Splits a WIDTH-bit add into SEG-bit slices, each slice mapped onto a single `adder_carry` chain, with the inter-slice carry registered between pipeline stages. It sits directly upstream of the `$alu` carry-chain mapping: each stage's slice add is a short `$alu` that maps onto a legal chain. It consumes `$alu` widths above MAX_CARRY_CHAIN that the chain mapper rejects.

## Interface
- WIDTH, 64: operand and result width in bits; must be ≥ 2.
- SEG, 32: slice width in bits; must satisfy 2 ≤ SEG ≤ MAX_CARRY_CHAIN.
- Derived NSEG = ceil(WIDTH/SEG): number of slices and number of pipeline stages.
- Derived LAST = WIDTH − (NSEG−1)·SEG: width of the top slice.

Ports (reset is asynchronous and active-high):
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operand beat valid
- in_ready  output  1  block accepts a beat this cycle
- a  input  WIDTH  operand A, unsigned bit vector
- b  input  WIDTH  operand B
- sub  input  1  1: B is inverted before the add (BI semantics)
- ci  input  1  carry-in to bit 0
- out_valid  output  1  result beat valid
- out_ready  input  1  downstream accepts the result
- y  output  WIDTH  sum
- co  output  1  carry-out of bit WIDTH−1
- ovf  output  1  signed overflow; present only when RS_SEG_ADDER_OVF_EN is defined

## Operation
- Function: y = (a + (sub ? ~b : b) + ci) mod 2^WIDTH; co = bit WIDTH of the full-precision sum.
- Stage k (0..NSEG−1) adds slice k of A and of B' = sub ? ~b : b.
  - Stage 0 carry-in is ci.
  - Stage k>0 carry-in is the carry registered out of stage k−1.
  - Slice k covers bits [k·SEG +: SEG]; the top slice is LAST bits wide.
- Operand skew:
  - Slices not yet consumed travel in a per-stage register triangle: stage k holds A/B' slices k..NSEG−1.
  - sub is applied once, at capture into stage 0.
- Result deskew: a sum slice produced at stage k is carried forward in stage registers to the output, so all of y emerges in the same cycle.
- Each stage holds a valid bit v[k]. out_valid = v[NSEG−1]; y and co are driven from the last-stage registers.
- Flow control uses a single global advance: adv = ~out_valid | out_ready; in_ready = adv.
  - On adv, every stage loads from its predecessor and v[0] loads in_valid.
  - With adv low, all registers hold, including bubbles. There is no bubble collapse.
- In-slice arithmetic is written as plain `+` of SEG+1 bits so that it maps through the chain mapper. No explicit `adder_carry` instantiation.

## Timing
- Reset:
  - All v[k] = 0, out_valid = 0, y = 0, co = 0, ovf = 0.
  - in_ready = 1 during and after reset.
- Latency: a beat accepted in cycle t (in_valid & in_ready) presents out_valid = 1 in cycle t+NSEG, provided adv stays high.
- Throughput: one beat per cycle while out_ready = 1.
- Backpressure:
  - out_valid & ~out_ready → in_ready = 0 in the same cycle (combinational).
  - y and co are stable until the cycle after out_ready rises.
- Simultaneous accept and output: both occur on the same edge when adv = 1; no beat is lost or duplicated.
- NSEG = 1 degenerates to a single registered add with latency 1.
- Reset asserted mid-stream:
  - All in-flight beats are discarded immediately (asynchronous).
  - The first beat after deassertion appears exactly NSEG cycles after its acceptance.
- Wrap-around: the all-ones + 1 carry propagates across every slice boundary, one stage per cycle. y = 0, co = 1.

## Configuration
- RS_SEG_ADDER_OVF_EN defined:
  - The ovf port exists.
  - The sign bits of a and B' (bit WIDTH−1) are carried alongside the pipeline.
  - ovf = (a_msb == b'_msb) & (y[WIDTH−1] != a_msb), registered with y.
- Not defined:
  - The ovf port and its sign-bit pipeline registers are absent.
  - All other behaviour is unchanged.

## Test plan
WIDTH=40, SEG=16 (NSEG=3, LAST=8), out_ready=1 unless stated.
- Reset release, then a=40'hFF_FFFF_FFFF, b=0, ci=1, sub=0 → out_valid 3 cycles later, y=0, co=1 (full-chain carry ripple across both boundaries).
- a=40'h00_0001_0000, b=1, sub=1, ci=1 → y=40'h00_0000_FFFF, co=1. Then a=0, b=1, sub=1, ci=1 → y=40'hFF_FFFF_FFFF, co=0.
- Back-to-back random stream of 1000 beats with out_ready toggling pseudo-randomly → outputs match the reference model in order, no drops or duplicates, and y/co are held stable while out_valid & ~out_ready.
- Hold out_ready=0 with the pipe full (3 beats in flight) for 5 cycles → in_ready=0 throughout. Then release → the 3 results drain on 3 consecutive cycles.
- Assert rst for 1 cycle with 2 beats in flight → out_valid=0 immediately. A new beat accepted after reset appears exactly 3 cycles later.
- With RS_SEG_ADDER_OVF_EN: a=40'h7F_FFFF_FFFF, b=1, sub=0, ci=0 → ovf=1, y=40'h80_0000_0000. Without the macro → the design compiles with no ovf port.
